multi_push_multi_pop_fifo_v2: RTL and testbench
===============================================

// Module: multi_push_multi_pop_fifo_v2
// PURPOSE
//  Parametrised multi-lane FIFO. Each cycle it accepts 0..NI words and releases 0..NO words.
//  Successor to the UART-path multi-push/multi-pop FIFO, adding:
//   - any depth D, not only powers of two
//   - occupancy output, almost-full / almost-empty flags
//   - synchronous flush
//   - request clamping, with sticky overflow/underflow error flags
//  Sits between burst producers/consumers in the UART and FFT datapaths.
// PARAMETERS
//  W   16      data word width
//  D   16      depth in words; any integer >= max(NI,NO)
//  NI  2       max words pushed per cycle
//  NO  2       max words popped per cycle
//  AF  D-2     almost_full asserts when count >= AF
//  AE  2       almost_empty asserts when count <= AE
// PORTS
//  clk           in   1                 clock, rising edge
//  rst_n         in   1                 async reset, active-low
//  flush         in   1                 sync clear of contents; highest priority
//  push          in   $clog2(NI+1)      requested push count
//  push_data     in   NI x W            lane i valid for i < push
//  pop           in   $clog2(NO+1)      requested pop count
//  pop_data      out  NO x W            lane j = j-th oldest word; valid for j < can_pop
//  can_push      out  $clog2(NI+1)      min(NI, D-count)
//  can_pop       out  $clog2(NO+1)      min(NO, count)
//  count         out  $clog2(D+1)       occupancy
//  almost_full   out  1                 count >= AF
//  almost_empty  out  1                 count <= AE
//  overflow      out  1                 sticky: push > can_push seen
//  underflow     out  1                 sticky: pop > can_pop seen
//  err_clr       in   1                 sync clear of both sticky flags
// BEHAVIOUR
//  - Reset (rst_n low, async): rd_ptr = wr_ptr = count = 0.
//    Outputs: can_pop = 0, can_push = min(NI,D), almost_empty = 1, almost_full = 0,
//    overflow = underflow = 0. Storage is not reset.
//  - can_push, can_pop and the flags derive from registered state only.
//    A same-cycle pop never raises can_push, and vice versa.
//  - Accepted counts: pa = min(push, can_push), qa = min(pop, can_pop). Excess requests are dropped.
//  - Write: lane i < pa goes to mem[(wr_ptr+i) mod D].
//  - Read: pop_data[j] = mem[(rd_ptr+j) mod D], combinational first-word fall-through, 0 cycles latency.
//  - Next state: wr_ptr += pa mod D; rd_ptr += qa mod D; count += pa - qa.
//    Simultaneous push and pop in the same cycle is legal.
//  - Modulo wrap is done by compare-and-subtract (sum >= D ? sum-D : sum). No power-of-two masking.
//  - Arithmetic is evaluated at $clog2(D+max(NI,NO)) bits to avoid truncation before the compare.
//  - Full (count == D): can_push = 0; any push sets overflow and writes nothing.
//  - Empty (count == 0): can_pop = 0; any pop sets underflow; pop_data is don't-care.
//  - flush = 1: pointers and count go to 0 next edge; push and pop that cycle are ignored.
//    Sticky flags are unaffected by flush.
//  - err_clr: flags go to 0 next edge. A new error in the same cycle wins (flag stays 1).
//  - Reset asserted mid-burst: state clears immediately. The first edge after release behaves as from empty.
// STRUCTURE
//  - Package mpmp_fifo_pkg: function wrap_add(ptr, inc, D) and function min_u(a, b).
//  - Sub-module mpmp_fifo_ptr: modulo-D pointer register with inc/flush.
//    Instantiated twice, as wr_ptr and rd_ptr.
//  - Top level holds count, the flag registers, the storage array and the read/write lane muxes.
// TESTING (D=10, NI=3, NO=2, AF=8, AE=2)
//  1. Reset release -> count=0, can_push=3, can_pop=0, almost_empty=1, flags=0.
//  2. push=3 A,B,C -> next cycle count=3, can_pop=2, pop_data={B,A}.
//     Then pop=2 -> pop_data[0]=C, count=1.
//  3. Fill 9 words, then push=3 -> only 1 word accepted, count=10, overflow=1, can_push=0.
//     Then err_clr -> overflow=0.
//  4. Wrap: cycle so wr_ptr=9; push=3 X,Y,Z -> words land in slots 9,0,1.
//     Popping returns X,Y,Z in order.
//  5. count=5, push=3 with pop=2 in the same cycle -> count=6, order preserved, no flags.
//  6. count=4, flush with push=3 -> count=0, can_pop=0, nothing written.
//     Then pop=1 -> underflow=1.

Source files
------------

// File: rtl/mpmp_fifo_pkg.sv
// rtl/mpmp_fifo_pkg.sv - shared helpers for the multi-push/multi-pop FIFO
package mpmp_fifo_pkg;

  // Modulo-d add for ptr < d and inc <= d; a single conditional subtract suffices.
  function automatic int unsigned wrap_add(input int unsigned ptr,
                                           input int unsigned inc,
                                           input int unsigned d);
    int unsigned sum;
    sum = ptr + inc;
    return (sum >= d) ? (sum - d) : sum;
  endfunction

  // Unsigned minimum, used for request clamping and capacity reporting.
  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/mpmp_fifo_ptr.sv
// rtl/mpmp_fifo_ptr.sv - modulo-D pointer register with increment and flush
module mpmp_fifo_ptr
  import mpmp_fifo_pkg::*;
#(
  parameter int unsigned D       = 16,
  parameter int unsigned MAX_INC = 2,
  parameter int unsigned INC_W   = 2,
  localparam int unsigned PW     = (D > 1) ? $clog2(D) : 1,
  // Wide enough to hold ptr + inc before the wrap compare.
  localparam int unsigned AW     = $clog2(D + MAX_INC) + 1
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [INC_W-1:0] inc,
  output logic [PW-1:0]    ptr
);

  logic [AW-1:0] sum;
  logic [AW-1:0] wrapped;

  // Compare-and-subtract wrap; D need not be a power of two.
  always_comb begin
    sum     = AW'(ptr) + AW'(inc);
    wrapped = (sum >= AW'(D)) ? (sum - AW'(D)) : sum;
  end

  // Pointer register: flush dominates the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (flush) begin
      ptr <= '0;
    end else begin
      ptr <= PW'(wrapped);
    end
  end

endmodule

// File: rtl/multi_push_multi_pop_fifo_v2.sv
// rtl/multi_push_multi_pop_fifo_v2.sv - any-depth multi-lane FIFO with clamping and sticky errors
module multi_push_multi_pop_fifo_v2
  import mpmp_fifo_pkg::*;
#(
  parameter int unsigned W  = 16,
  parameter int unsigned D  = 16,
  parameter int unsigned NI = 2,
  parameter int unsigned NO = 2,
  parameter int          AF = D - 2,
  parameter int          AE = 2,
  localparam int unsigned IW = $clog2(NI + 1),
  localparam int unsigned OW = $clog2(NO + 1),
  localparam int unsigned CW = $clog2(D + 1)
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [IW-1:0]          push,
  input  logic [NI-1:0][W-1:0]   push_data,
  input  logic [OW-1:0]          pop,
  output logic [NO-1:0][W-1:0]   pop_data,
  output logic [IW-1:0]          can_push,
  output logic [OW-1:0]          can_pop,
  output logic [CW-1:0]          count,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   err_clr
);

  localparam int unsigned PW = (D > 1) ? $clog2(D) : 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IW-1:0] push_acc;
  logic [OW-1:0] pop_acc;
  logic          ovf_now;
  logic          unf_now;
  logic [W-1:0]  mem [D];

  // Capacity, flags and clamped counts come from registered occupancy only.
  always_comb begin
    can_push     = IW'(min_u(NI, D - 32'(count)));
    can_pop      = OW'(min_u(NO, 32'(count)));
    push_acc     = IW'(min_u(32'(push), 32'(can_push)));
    pop_acc      = OW'(min_u(32'(pop), 32'(can_pop)));
    almost_full  = (int'(count) >= AF);
    almost_empty = (int'(count) <= AE);
    // A flushed cycle ignores its requests, so they cannot raise errors.
    ovf_now      = !flush && (push > can_push);
    unf_now      = !flush && (pop > can_pop);
  end

  mpmp_fifo_ptr #(.D(D), .MAX_INC(NI), .INC_W(IW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .inc   (push_acc),
    .ptr   (wr_ptr)
  );

  mpmp_fifo_ptr #(.D(D), .MAX_INC(NO), .INC_W(OW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .inc   (pop_acc),
    .ptr   (rd_ptr)
  );

  // Write lanes: accepted lane i lands at wr_ptr + i, wrapped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NI); i++) begin
      if (!flush && (i < int'(push_acc))) begin
        mem[PW'(wrap_add(32'(wr_ptr), i, D))] <= push_data[i];
      end
    end
  end

  // Read lanes: fall-through view of the NO oldest words.
  always_comb begin
    for (int j = 0; j < int'(NO); j++) begin
      pop_data[j] = mem[PW'(wrap_add(32'(rd_ptr), j, D))];
    end
  end

  // Occupancy: never underflows because pop_acc <= count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= CW'(32'(count) + 32'(push_acc) - 32'(pop_acc));
    end
  end

  // Sticky error flags: a fresh error outranks err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (err_clr ? 1'b0 : overflow)  | ovf_now;
      underflow <= (err_clr ? 1'b0 : underflow) | unf_now;
    end
  end

endmodule

// File: tb/tb_multi_push_multi_pop_fifo_v2.sv
// tb/tb_multi_push_multi_pop_fifo_v2.sv - scoreboard bench for multi_push_multi_pop_fifo_v2
module tb_multi_push_multi_pop_fifo_v2;

  localparam int W  = 16;
  localparam int D  = 10;
  localparam int NI = 3;
  localparam int NO = 2;
  localparam int AF = 8;
  localparam int AE = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 flush;
  logic [1:0]           push;
  logic [NI-1:0][W-1:0] push_data;
  logic [1:0]           pop;
  logic [NO-1:0][W-1:0] pop_data;
  logic [1:0]           can_push;
  logic [1:0]           can_pop;
  logic [3:0]           count;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 overflow;
  logic                 underflow;
  logic                 err_clr;

  always #5 clk = ~clk;

  multi_push_multi_pop_fifo_v2 #(
    .W(W), .D(D), .NI(NI), .NO(NO), .AF(AF), .AE(AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .push         (push),
    .push_data    (push_data),
    .pop          (pop),
    .pop_data     (pop_data),
    .can_push     (can_push),
    .can_pop      (can_pop),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_count = 0;
  bit m_ov = 1'b0;
  bit m_un = 1'b0;
  logic [W-1:0] sb[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got[$];

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Drive one cycle at the falling edge, update the model, capture popped words.
  task automatic step(input int pn, input logic [W-1:0] d0, input logic [W-1:0] d1,
                      input logic [W-1:0] d2, input int qn,
                      input bit fl = 1'b0, input bit ec = 1'b0);
    int cp, cq, pa, qa;
    push = 2'(pn);
    push_data[0] = d0;
    push_data[1] = d1;
    push_data[2] = d2;
    pop = 2'(qn);
    flush = fl;
    err_clr = ec;
    #1;
    cp = min2(NI, D - m_count);
    cq = min2(NO, m_count);
    pa = min2(pn, cp);
    qa = min2(qn, cq);
    if (fl) begin
      sb.delete();
      m_count = 0;
      m_ov = ec ? 1'b0 : m_ov;
      m_un = ec ? 1'b0 : m_un;
    end else begin
      for (int j = 0; j < qa; j++) begin
        exp_q.push_back(sb.pop_front());
        got.push_back(pop_data[j]);
      end
      if (pa > 0) sb.push_back(d0);
      if (pa > 1) sb.push_back(d1);
      if (pa > 2) sb.push_back(d2);
      m_count = m_count + pa - qa;
      m_ov = (ec ? 1'b0 : m_ov) | (pn > cp);
      m_un = (ec ? 1'b0 : m_un) | (qn > cq);
    end
    @(posedge clk);
    @(negedge clk);
    push = '0;
    pop = '0;
    flush = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; err_clr = 1'b0; push = '0; pop = '0; push_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (can_push !== 2'd3) begin n_bad++; $display("FAIL reset_can_push got %0d want 3", can_push); end
    n_cmp++; if (can_pop !== 2'd0) begin n_bad++; $display("FAIL reset_can_pop got %0d want 0", can_pop); end
    n_cmp++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      n_bad++; $display("FAIL reset_ae_af got %b%b want 10", almost_empty, almost_full); end
    n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags got %b%b want 00", overflow, underflow); end
  endtask

  task automatic test_basic();
    logic [W-1:0] a, e;
    step(3, 16'hA000, 16'hB000, 16'hC000, 0);
    n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL basic_count got %0d want 3", count); end
    n_cmp++; if (can_pop !== 2'd2) begin n_bad++; $display("FAIL basic_can_pop got %0d want 2", can_pop); end
    n_cmp++; if (pop_data[0] !== 16'hA000 || pop_data[1] !== 16'hB000) begin
      n_bad++; $display("FAIL basic_fwft got %h %h want a000 b000", pop_data[0], pop_data[1]); end
    step(0, '0, '0, '0, 2);
    n_cmp++; if (pop_data[0] !== 16'hC000) begin n_bad++; $display("FAIL basic_head got %h want c000", pop_data[0]); end
    n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL basic_count2 got %0d want 1", count); end
    step(0, '0, '0, '0, 1);
    while (got.size() > 0) begin
      a = got.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (a !== e) begin n_bad++; $display("FAIL basic_data got %h want %h", a, e); end
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] a, e;
    for (int k = 0; k < 3; k++) step(3, 16'h1000 + 16'(k*3), 16'h1001 + 16'(k*3), 16'h1002 + 16'(k*3), 0);
    n_cmp++; if (count !== 4'd9 || almost_full !== 1'b1) begin
      n_bad++; $display("FAIL ovf_fill got count %0d af %b want 9 1", count, almost_full); end
    step(3, 16'h2000, 16'h2001, 16'h2002, 0);
    n_cmp++; if (count !== 4'd10) begin n_bad++; $display("FAIL ovf_count got %0d want 10", count); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
    n_cmp++; if (can_push !== 2'd0) begin n_bad++; $display("FAIL ovf_can_push got %0d want 0", can_push); end
    step(0, '0, '0, '0, 0, 1'b0, 1'b1);
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clr got %b want 0", overflow); end
    for (int k = 0; k < 5; k++) step(0, '0, '0, '0, 2);
    n_cmp++; if (count !== 4'd0 || underflow !== 1'b0) begin
      n_bad++; $display("FAIL ovf_drain got count %0d un %b want 0 0", count, underflow); end
    while (got.size() > 0) begin
      a = got.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (a !== e) begin n_bad++; $display("FAIL ovf_data got %h want %h", a, e); end
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] a, e;
    // Pointers sit at 3 here; six pushes and pops bring both to 9.
    step(3, 16'h3000, 16'h3001, 16'h3002, 0);
    step(3, 16'h3003, 16'h3004, 16'h3005, 0);
    for (int k = 0; k < 3; k++) step(0, '0, '0, '0, 2);
    step(3, 16'h5858, 16'h5959, 16'h5A5A, 0);
    n_cmp++; if (pop_data[0] !== 16'h5858 || pop_data[1] !== 16'h5959) begin
      n_bad++; $display("FAIL wrap_fwft got %h %h want 5858 5959", pop_data[0], pop_data[1]); end
    step(0, '0, '0, '0, 2);
    step(0, '0, '0, '0, 1);
    while (got.size() > 0) begin
      a = got.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (a !== e) begin n_bad++; $display("FAIL wrap_data got %h want %h", a, e); end
    end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] a, e;
    step(3, 16'h6000, 16'h6001, 16'h6002, 0);
    step(2, 16'h6003, 16'h6004, 16'h0000, 0);
    step(3, 16'h6005, 16'h6006, 16'h6007, 2);
    n_cmp++; if (count !== 4'd6) begin n_bad++; $display("FAIL simul_count got %0d want 6", count); end
    n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      n_bad++; $display("FAIL simul_flags got %b%b want 00", overflow, underflow); end
    for (int k = 0; k < 3; k++) step(0, '0, '0, '0, 2);
    while (got.size() > 0) begin
      a = got.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (a !== e) begin n_bad++; $display("FAIL simul_data got %h want %h", a, e); end
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] a, e;
    step(3, 16'h7000, 16'h7001, 16'h7002, 0);
    step(1, 16'h7003, 16'h0000, 16'h0000, 0);
    step(3, 16'h7777, 16'h7778, 16'h7779, 0, 1'b1);
    n_cmp++; if (count !== 4'd0 || can_pop !== 2'd0) begin
      n_bad++; $display("FAIL flush_state got count %0d can_pop %0d want 0 0", count, can_pop); end
    step(0, '0, '0, '0, 1);
    n_cmp++; if (underflow !== 1'b1) begin n_bad++; $display("FAIL flush_underflow got %b want 1", underflow); end
    step(1, 16'h7ABC, '0, '0, 0, 1'b0, 1'b1);
    n_cmp++; if (underflow !== 1'b0 || count !== 4'd1) begin
      n_bad++; $display("FAIL flush_after got un %b count %0d want 0 1", underflow, count); end
    step(0, '0, '0, '0, 1);
    while (got.size() > 0) begin
      a = got.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (a !== e) begin n_bad++; $display("FAIL flush_data got %h want %h", a, e); end
    end
  endtask

  task automatic test_reset_midburst();
    logic [W-1:0] a, e;
    step(3, 16'h8000, 16'h8001, 16'h8002, 0);
    push = 2'd3;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd0 || can_pop !== 2'd0 || can_push !== 2'd3) begin
      n_bad++; $display("FAIL midrst_state got %0d %0d %0d want 0 0 3", count, can_pop, can_push); end
    @(negedge clk);
    push = '0;
    rst_n = 1'b1;
    sb.delete(); m_count = 0; m_ov = 1'b0; m_un = 1'b0;
    step(2, 16'h9001, 16'h9002, '0, 0);
    n_cmp++; if (count !== 4'd2 || pop_data[0] !== 16'h9001) begin
      n_bad++; $display("FAIL midrst_after got count %0d head %h want 2 9001", count, pop_data[0]); end
    step(0, '0, '0, '0, 2);
    while (got.size() > 0) begin
      a = got.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (a !== e) begin n_bad++; $display("FAIL midrst_data got %h want %h", a, e); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, e;
    int pn, qn;
    bit fl, ec;
    for (int it = 0; it < 400; it++) begin
      fl = ($urandom_range(0, 24) == 0);
      ec = ($urandom_range(0, 7) == 0);
      if (fl) begin pn = 0; qn = 0; end
      else if (it < 200) begin pn = $urandom_range(0, 3); qn = $urandom_range(0, 2); end
      else begin pn = $urandom_range(0, 1); qn = $urandom_range(0, 2); end
      step(pn, 16'($urandom), 16'($urandom), 16'($urandom), qn, fl, ec);
      n_cmp++;
      if (int'(count) != m_count || int'(can_push) != min2(NI, D - m_count) ||
          int'(can_pop) != min2(NO, m_count)) begin
        n_bad++; $display("FAIL rand_counts it %0d got %0d %0d %0d want %0d %0d %0d", it,
          count, can_push, can_pop, m_count, min2(NI, D - m_count), min2(NO, m_count)); end
      n_cmp++;
      if (almost_full !== (m_count >= AF) || almost_empty !== (m_count <= AE) ||
          overflow !== m_ov || underflow !== m_un) begin
        n_bad++; $display("FAIL rand_flags it %0d got af%b ae%b ov%b un%b want af%b ae%b ov%b un%b", it,
          almost_full, almost_empty, overflow, underflow, m_count >= AF, m_count <= AE, m_ov, m_un); end
      while (got.size() > 0) begin
        a = got.pop_front(); e = exp_q.pop_front(); n_cmp++;
        if (a !== e) begin n_bad++; $display("FAIL rand_data it %0d got %h want %h", it, a, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_reset_midburst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
